// File: rtl/control_unit.sv
// Multicycle sequencing FSM for the 8-bit CPU datapath.
// Drives memory, PC, IR, register-file and ALU controls from opcode and zero.
//
// state  | meaning
// FETCH1 | read byte 1 into IR1, PC += 1
// FETCH2 | read byte 2 into IR2, PC += 1
// DECODE | datapath latches A/B, branch on opcode
// EXE    | ALU operation A op B
// ALUWB  | write ALU result to register file
// MADR   | pass A through ALU as memory address
// MRD    | memory read at address
// MWB    | write read data to register file
// MWR    | write register B to memory
// JMP    | PC <= IR2
// BR     | PC <= IR2 when A == 0
// HALT   | stopped until reset
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic       memEnable,
    output logic       adrSelect,
    output logic       pcEnable,
    output logic       pcSelect,
    output logic       ir1En,
    output logic       ir2En,
    output logic       op1Sel,
    output logic       op2Sel,
    output logic       regWrite,
    output logic       wbSel,
    output logic [2:0] aluControl,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH1 = 4'd0,  FETCH2 = 4'd1, DECODE = 4'd2, EXE  = 4'd3,
        ALUWB  = 4'd4,  MADR   = 4'd5, MRD    = 4'd6, MWB  = 4'd7,
        MWR    = 4'd8,  JMP    = 4'd9, BR     = 4'd10, HALT = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_en;
        logic       adr_sel;
        logic       pc_en;
        logic       pc_sel;
        logic       ir1_en;
        logic       ir2_en;
        logic       op1_sel;
        logic       op2_sel;
        logic       reg_write;
        logic       wb_sel;
        logic [2:0] alu;
        logic       halted;
    } ctrl_t;

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   is_store;

    // Controls for a state; opcode only matters when entering EXE.
    function automatic ctrl_t decode(input state_t st, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH1: begin c.ir1_en = 1'b1; c.pc_en = 1'b1; c.op2_sel = 1'b1; end
            FETCH2: begin c.ir2_en = 1'b1; c.pc_en = 1'b1; c.op2_sel = 1'b1; end
            EXE: begin
                c.op1_sel = 1'b1;
                case (op)
                    4'h2:    c.alu = 3'b001;
                    4'h3:    c.alu = 3'b010;
                    4'h4:    c.alu = 3'b011;
                    4'h5:    c.alu = 3'b100;
                    default: c.alu = 3'b000;
                endcase
            end
            ALUWB: c.reg_write = 1'b1;
            MADR:  begin c.op1_sel = 1'b1; c.alu = 3'b101; end
            MRD:   c.adr_sel = 1'b1;
            MWB:   begin c.reg_write = 1'b1; c.wb_sel = 1'b1; end
            MWR:   begin c.adr_sel = 1'b1; c.mem_en = 1'b1; end
            JMP:   begin c.pc_sel = 1'b1; c.pc_en = 1'b1; end
            // PC load in BR is gated by the live zero flag at the output.
            BR:    begin c.op1_sel = 1'b1; c.alu = 3'b101; c.pc_sel = 1'b1; end
            HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = FETCH1;
        case (cur)
            FETCH1: nxt = FETCH2;
            FETCH2: nxt = DECODE;
            DECODE: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: nxt = EXE;
                    4'h6, 4'h7:                   nxt = MADR;
                    4'h8:                         nxt = JMP;
                    4'h9:                         nxt = BR;
                    4'hF:                         nxt = HALT;
                    default:                      nxt = FETCH1;
                endcase
            end
            EXE:     nxt = ALUWB;
            MADR:    nxt = is_store ? MWR : MRD;
            MRD:     nxt = MWB;
            HALT:    nxt = HALT;
            default: nxt = FETCH1;
        endcase
    end

    // Controls are registered one state ahead so they line up with cur.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= FETCH1;
            ctrl_q   <= decode(FETCH1, 4'h0);
            is_store <= 1'b0;
        end else begin
            cur    <= nxt;
            ctrl_q <= decode(nxt, opcode);
            if (cur == DECODE)
                is_store <= (opcode == 4'h7);
        end
    end

    assign memEnable  = ~reset & ctrl_q.mem_en;
    assign adrSelect  = ~reset & ctrl_q.adr_sel;
    assign pcEnable   = ~reset & (ctrl_q.pc_en | ((cur == BR) & zero));
    assign pcSelect   = ~reset & ctrl_q.pc_sel;
    assign ir1En      = ~reset & ctrl_q.ir1_en;
    assign ir2En      = ~reset & ctrl_q.ir2_en;
    assign op1Sel     = ~reset & ctrl_q.op1_sel;
    assign op2Sel     = ~reset & ctrl_q.op2_sel;
    assign regWrite   = ~reset & ctrl_q.reg_write;
    assign wbSel      = ~reset & ctrl_q.wb_sel;
    assign aluControl = reset ? 3'b000 : ctrl_q.alu;
    assign halted     = ~reset & ctrl_q.halted;
    assign state      = cur;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected state and controls
// are queued as stimulus is applied and checked mid-cycle.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       memEnable, adrSelect, pcEnable, pcSelect, ir1En, ir2En;
    logic       op1Sel, op2Sel, regWrite, wbSel, halted;
    logic [2:0] aluControl;
    logic [3:0] state;

    logic [17:0] expq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          idx = 0;
    string       tag = "init";

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .memEnable(memEnable), .adrSelect(adrSelect), .pcEnable(pcEnable),
        .pcSelect(pcSelect), .ir1En(ir1En), .ir2En(ir2En),
        .op1Sel(op1Sel), .op2Sel(op2Sel), .regWrite(regWrite), .wbSel(wbSel),
        .aluControl(aluControl), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // {mem, adr, pcEn, pcSel, ir1, ir2, op1, op2, rw, wb, alu[2:0], halted}
    function automatic logic [13:0] spec_out(input logic [3:0] st, input logic [3:0] op,
                                             input logic z);
        logic mem, adr, pe, ps, i1, i2, o1, o2, rw, wb, h;
        logic [2:0] alu;
        {mem, adr, pe, ps, i1, i2, o1, o2, rw, wb, h} = '0;
        alu = 3'b000;
        case (st)
            4'd0:  begin pe = 1; i1 = 1; o2 = 1; end
            4'd1:  begin pe = 1; i2 = 1; o2 = 1; end
            4'd3:  begin
                o1 = 1;
                if (op == 4'h2) alu = 3'b001;
                else if (op == 4'h3) alu = 3'b010;
                else if (op == 4'h4) alu = 3'b011;
                else if (op == 4'h5) alu = 3'b100;
            end
            4'd4:  rw = 1;
            4'd5:  begin o1 = 1; alu = 3'b101; end
            4'd6:  adr = 1;
            4'd7:  begin rw = 1; wb = 1; end
            4'd8:  begin adr = 1; mem = 1; end
            4'd9:  begin ps = 1; pe = 1; end
            4'd10: begin o1 = 1; alu = 3'b101; ps = 1; pe = z; end
            4'd11: h = 1;
            default: ;
        endcase
        return {mem, adr, pe, ps, i1, i2, o1, o2, rw, wb, alu, h};
    endfunction

    // Apply inputs for one cycle, queue its expectation, check at negedge.
    task automatic cyc(input logic r, input logic [3:0] op, input logic z,
                       input logic [3:0] st);
        logic [17:0] obs;
        logic [17:0] exp_v;
        reset = r;
        opcode = op;
        zero = z;
        expq.push_back({st, r ? 14'd0 : spec_out(st, op, z)});
        @(negedge clk);
        obs = {state, memEnable, adrSelect, pcEnable, pcSelect, ir1En, ir2En,
               op1Sel, op2Sel, regWrite, wbSel, aluControl, halted};
        exp_v = expq.pop_front();
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cyc%0d observed=%h expected=%h", tag, idx, obs, exp_v);
        end
        idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string t, input logic [3:0] op, input logic z,
                       input int n, input logic [23:0] seq);
        tag = t;
        idx = 0;
        for (int i = 0; i < n; i++)
            cyc(1'b0, op, z, seq[23-4*i -: 4]);
    endtask

    initial begin
        reset = 1'b1;
        opcode = 4'h0;
        zero = 1'b0;
        @(posedge clk);
        #1;

        tag = "reset";
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h0, 1'b0, 4'd0);

        run("sub",  4'h2, 1'b0, 5, 24'h012340);
        run("add",  4'h1, 1'b1, 5, 24'h012340);
        run("and",  4'h3, 1'b0, 5, 24'h012340);
        run("or",   4'h4, 1'b1, 5, 24'h012340);
        run("xor",  4'h5, 1'b0, 5, 24'h012340);
        run("st",   4'h7, 1'b0, 5, 24'h012580);

        // LD with opcode changing after DECODE must still follow the load path.
        tag = "ld";
        idx = 0;
        cyc(1'b0, 4'h6, 1'b0, 4'd0);
        cyc(1'b0, 4'h6, 1'b0, 4'd1);
        cyc(1'b0, 4'h6, 1'b0, 4'd2);
        cyc(1'b0, 4'h7, 1'b0, 4'd5);
        cyc(1'b0, 4'h7, 1'b0, 4'd6);
        cyc(1'b0, 4'h7, 1'b0, 4'd7);

        run("beqz_taken",  4'h9, 1'b1, 4, 24'h012A00);
        run("beqz_not",    4'h9, 1'b0, 4, 24'h012A00);
        run("jmp",         4'h8, 1'b0, 4, 24'h012900);
        run("nop_undef",   4'hC, 1'b0, 3, 24'h012000);
        run("nop_zero",    4'h0, 1'b1, 3, 24'h012000);

        // Reset while in EXE: no writeback, back to FETCH1.
        run("rst_exe", 4'h1, 1'b0, 3, 24'h012000);
        cyc(1'b1, 4'h1, 1'b0, 4'd3);
        run("rst_exe_after", 4'h1, 1'b0, 5, 24'h012340);

        run("halt", 4'hF, 1'b0, 3, 24'h012000);
        tag = "halt_hold";
        idx = 0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'(i), 1'(i), 4'd11);
        tag = "halt_rst";
        cyc(1'b1, 4'hF, 1'b0, 4'd11);
        run("post_halt", 4'h0, 1'b0, 3, 24'h012000);
        run("post_halt_sub", 4'h2, 1'b1, 5, 24'h012340);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
